instr_fetch: RTL and testbench

//   Reader side of the program counter interface. Takes the 16-bit address the PC drives and fetches one
//   16-bit instruction as two byte reads over the req/ack memory bus. Presents the instruction to the

---
 rtl/instr_fetch.sv | 81 ++++++++
 tb/tb_instr_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetches a 16-bit instruction as two byte reads (hi first) over req/ack, hands it to the decoder, then pulses pc_inc; ports clk/clr, pc_addr/fetch_req/fetch_busy, mem_addr/mem_rd/mem_rdata/mem_ack, instr/instr_valid/instr_ready, pc_inc, fault
module instr_fetch #(
  parameter int ADDR_W  = 16,
  parameter int MEM_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [ADDR_W-1:0]    pc_addr,
  input  logic                 fetch_req,
  output logic                 fetch_busy,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic [MEM_W-1:0]     mem_rdata,
  input  logic                 mem_ack,
  output logic [2*MEM_W-1:0]   instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic                 pc_inc,
  output logic                 fault
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, RD_HI, GAP, RD_LO, HOLD, FLT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      cnt         <= '0;
      fetch_busy  <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_inc      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pc_inc <= 1'b0;
      case (state)
        IDLE: if (fetch_req) begin
          mem_addr   <= pc_addr;
          mem_rd     <= 1'b1;
          cnt        <= '0;
          fetch_busy <= 1'b1;
          state      <= RD_HI;
        end
        RD_HI, RD_LO: if (mem_ack) begin
          mem_rd <= 1'b0;
          if (state == RD_HI) begin
            instr[2*MEM_W-1 -: MEM_W] <= mem_rdata;
            mem_addr <= mem_addr + 1'b1;
            state    <= GAP;
          end else begin
            instr[MEM_W-1:0] <= mem_rdata;
            instr_valid      <= 1'b1;
            state            <= HOLD;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          mem_rd <= 1'b0;
          fault  <= 1'b1;
          state  <= FLT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        GAP: begin
          mem_rd <= 1'b1;
          cnt    <= '0;
          state  <= RD_LO;
        end
        HOLD: if (instr_ready) begin
          instr_valid <= 1'b0;
          pc_inc      <= 1'b1;
          fetch_busy  <= 1'b0;
          state       <= IDLE;
        end
        FLT: state <= FLT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against a transaction-level model
module tb_instr_fetch;
  localparam int TO = 15;
  logic clk = 0, clr = 0, fetch_req = 0, mem_ack = 0, instr_ready = 0;
  logic [15:0] pc_addr = 0;
  logic [7:0] mem_rdata = 0;
  logic fetch_busy, mem_rd, instr_valid, pc_inc, fault;
  logic [15:0] mem_addr, instr;
  instr_fetch #(.ADDR_W(16), .MEM_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .pc_addr(pc_addr), .fetch_req(fetch_req), .fetch_busy(fetch_busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_inc(pc_inc), .fault(fault)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [65536];
  int tests = 0, fails = 0;
  bit run = 0;
  bit m_busy, m_rd, m_gap, m_valid, m_inc, m_fault;
  logic [15:0] m_addr, m_a, m_instr;
  int m_n, m_wait;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  // Transaction-level reference: which byte of which fetch is outstanding, how long it has waited
  always @(posedge clk) begin : model
    bit busy, rd, gap, valid, inc, flt;
    logic [15:0] addr, a, ins;
    int n, w;
    busy = m_busy; rd = m_rd; gap = m_gap; valid = m_valid; flt = m_fault;
    addr = m_addr; a = m_a; ins = m_instr; n = m_n; w = m_wait;
    inc = 0;
    if (clr) begin
      busy = 0; rd = 0; gap = 0; valid = 0; flt = 0; addr = 0; a = 0; ins = 0; n = 0; w = 0;
    end else if (!busy) begin
      if (fetch_req) begin
        a = pc_addr; addr = pc_addr; rd = 1; busy = 1; n = 0; w = 0;
      end
    end else if (flt) begin
      busy = 1;
    end else if (rd) begin
      if (mem_ack) begin
        rd = 0;
        if (n == 0) begin ins[15:8] = mem[addr]; addr = a + 16'd1; gap = 1; end
        else begin ins[7:0] = mem[addr]; valid = 1; end
        n++;
      end else begin
        w++;
        if (w == TO) begin flt = 1; rd = 0; end
      end
    end else if (gap) begin
      gap = 0; rd = 1; w = 0;
    end else if (valid && instr_ready) begin
      valid = 0; inc = 1; busy = 0;
    end
    m_busy <= busy; m_rd <= rd; m_gap <= gap; m_valid <= valid; m_inc <= inc; m_fault <= flt;
    m_addr <= addr; m_a <= a; m_instr <= ins; m_n <= n; m_wait <= w;
  end
  always @(negedge clk) if (run) begin
    chk("busy", fetch_busy, m_busy);
    chk("mem_rd", mem_rd, m_rd);
    chk("mem_addr", mem_addr, m_addr);
    chk("instr", instr, m_instr);
    chk("instr_valid", instr_valid, m_valid);
    chk("pc_inc", pc_inc, m_inc);
    chk("fault", fault, m_fault);
  end
  // One cycle of stimulus; the memory acks only real reads (with probability ap) and sprays noise acks otherwise
  task automatic cyc(input bit r, input logic [15:0] pa, input int ap, input int rp, input bit c);
    @(negedge clk);
    clr = c; fetch_req = r; pc_addr = pa;
    if (m_rd) begin
      mem_ack = $urandom_range(0, 99) < ap;
      mem_rdata = mem_ack ? mem[m_addr] : 8'($urandom);
    end else begin
      mem_ack = $urandom_range(0, 3) == 0;
      mem_rdata = 8'($urandom);
    end
    instr_ready = $urandom_range(0, 99) < rp;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD; mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
    repeat (3) cyc(0, 16'h0000, 0, 0, 1);
    run = 1;
    cyc(0, 16'h0000, 0, 0, 0);
    chk("rst_busy", fetch_busy, 0); chk("rst_rd", mem_rd, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_instr", instr, 0); chk("rst_valid", instr_valid, 0); chk("rst_inc", pc_inc, 0);
    chk("rst_fault", fault, 0);
    repeat (6) cyc(0, 16'h1234, 100, 100, 0);
    chk("idle_busy", fetch_busy, 0); chk("idle_instr", instr, 0);
    // basic fetch with one wait cycle per read
    cyc(1, 16'h0010, 0, 0, 0);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_rd_hi", mem_rd, 1); chk("t2_addr_hi", mem_addr, 16'h0010);
    cyc(0, 16'h0010, 100, 0, 0);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_gap_rd", mem_rd, 0); chk("t2_addr_lo", mem_addr, 16'h0011);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_rd_lo", mem_rd, 1);
    cyc(0, 16'h0010, 100, 0, 0);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_valid", instr_valid, 1); chk("t2_instr", instr, 16'hABCD);
    repeat (2) cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_held", instr, 16'hABCD); chk("t2_no_inc", pc_inc, 0);
    cyc(0, 16'h0010, 0, 100, 0);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_inc", pc_inc, 1); chk("t2_valid_drop", instr_valid, 0);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t2_inc_pulse", pc_inc, 0);
    // address wrap
    cyc(1, 16'hFFFF, 0, 0, 0);
    cyc(0, 16'hFFFF, 100, 0, 0);
    cyc(0, 16'hFFFF, 0, 0, 0);
    chk("t3_wrap_addr", mem_addr, 16'h0000); chk("t3_gap", mem_rd, 0);
    cyc(0, 16'hFFFF, 100, 0, 0);
    chk("t3_rd_lo", mem_rd, 1);
    cyc(0, 16'hFFFF, 0, 100, 0);
    chk("t3_instr", instr, 16'h1234);
    cyc(0, 16'hFFFF, 0, 0, 0);
    chk("t3_inc", pc_inc, 1);
    cyc(0, 16'hFFFF, 0, 0, 0);
    // timeout on the high read
    cyc(1, 16'h4000, 0, 0, 0);
    repeat (15) cyc(0, 16'h4000, 0, 0, 0);
    chk("t4_no_fault_yet", fault, 0);
    cyc(0, 16'h4000, 0, 0, 0);
    chk("t4_fault", fault, 1); chk("t4_rd", mem_rd, 0); chk("t4_busy", fetch_busy, 1);
    repeat (4) cyc(1, 16'h4000, 100, 100, 0);
    chk("t4_sticky", fault, 1); chk("t4_valid", instr_valid, 0);
    cyc(0, 16'h4000, 0, 0, 1);
    cyc(0, 16'h4000, 0, 0, 0);
    chk("t4_clr_fault", fault, 0); chk("t4_clr_busy", fetch_busy, 0);
    // ack on the last allowed cycle wins over the timeout
    cyc(1, 16'h5000, 0, 0, 0);
    repeat (14) cyc(0, 16'h5000, 0, 0, 0);
    cyc(0, 16'h5000, 100, 0, 0);
    cyc(0, 16'h5000, 0, 0, 0);
    chk("t4b_no_fault", fault, 0); chk("t4b_gap", mem_rd, 0); chk("t4b_addr", mem_addr, 16'h5001);
    cyc(0, 16'h5000, 100, 0, 0);
    cyc(0, 16'h5000, 0, 100, 0);
    chk("t4b_valid", instr_valid, 1);
    cyc(0, 16'h5000, 0, 0, 0);
    chk("t4b_inc", pc_inc, 1);
    // clear mid-fetch
    cyc(1, 16'h0100, 0, 0, 0);
    cyc(0, 16'h0100, 100, 0, 0);
    cyc(0, 16'h0100, 0, 0, 0);
    cyc(0, 16'h0100, 0, 0, 1);
    cyc(0, 16'h0100, 0, 0, 0);
    chk("t5_busy", fetch_busy, 0); chk("t5_instr", instr, 0); chk("t5_rd", mem_rd, 0);
    chk("t5_inc", pc_inc, 0);
    cyc(1, 16'h0010, 0, 0, 0);
    cyc(0, 16'h0010, 100, 0, 0);
    cyc(0, 16'h0010, 0, 0, 0);
    cyc(0, 16'h0010, 100, 0, 0);
    cyc(0, 16'h0010, 0, 100, 0);
    chk("t5_refetch", instr, 16'hABCD);
    cyc(0, 16'h0010, 0, 0, 0);
    chk("t5_inc2", pc_inc, 1);
    // request held high, pc changes mid-fetch, back-to-back accept in the pc_inc cycle
    cyc(1, 16'h0200, 0, 0, 0);
    cyc(1, 16'h0300, 100, 0, 0);
    cyc(1, 16'h0300, 0, 0, 0);
    chk("t6_orig_addr", mem_addr, 16'h0201);
    cyc(1, 16'h0300, 100, 0, 0);
    cyc(1, 16'h0300, 0, 100, 0);
    chk("t6_instr", instr, {mem[16'h0200], mem[16'h0201]});
    cyc(1, 16'h0300, 0, 0, 0);
    chk("t6_inc", pc_inc, 1); chk("t6_idle", fetch_busy, 0);
    cyc(0, 16'h0300, 0, 0, 0);
    chk("t6_next_busy", fetch_busy, 1); chk("t6_next_addr", mem_addr, 16'h0300);
    cyc(0, 16'h0300, 100, 0, 0);
    cyc(0, 16'h0300, 0, 0, 0);
    cyc(0, 16'h0300, 100, 0, 0);
    cyc(0, 16'h0300, 0, 100, 0);
    cyc(0, 16'h0300, 0, 0, 0);
    // randomized traffic: varying ack/ready rates, rare clears, occasional timeouts
    for (int s = 0; s < 40; s++) begin
      int ap, rp;
      ap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(20, 100);
      rp = $urandom_range(10, 100);
      if (m_fault) cyc(0, 16'($urandom), 0, 0, 1);
      repeat (80) cyc($urandom_range(0, 2) == 0, 16'($urandom), ap, rp, $urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
